// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter with grant hold: an owner keeps the resource until done or req drop.
// Optional macro ARB_TIMEOUT_EN revokes a grant after MAX_HOLD cycles when others are waiting.
module rr_grant_scheduler #(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int ID_W     = $clog2(NUM_REQ),
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic               preempt
);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic               r_valid, w_valid_nxt;
    logic [ID_W-1:0]    r_id, w_id_nxt;
    logic [ID_W-1:0]    r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_hold, w_hold_nxt;
    logic [ID_W-1:0]    w_winner, w_cand;
    logic               w_found, w_release, w_hold_max;
    int                 w_idx;
`ifdef ARB_TIMEOUT_EN
    logic               r_preempt, w_preempt_nxt;
`endif

    // Search starts just after the last winner, so the previous owner ranks last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        w_idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            w_cand = ID_W'(w_idx);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_release  = done[r_id] | ~req[r_id];
    assign w_hold_max = (r_hold == CNT_W'(MAX_HOLD));

    // NOTE: every next-state signal gets its hold value first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
`ifdef ARB_TIMEOUT_EN
        w_preempt_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = w_winner;
                    w_last_nxt  = w_winner;
                    w_hold_nxt  = CNT_W'(1);
                end
            end
            S_OWN: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_id_nxt    = '0;
                    w_hold_nxt  = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_hold_max && |(req & ~r_grant)) begin
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_id_nxt      = '0;
                    w_hold_nxt    = '0;
                    w_preempt_nxt = 1'b1;
                end
`endif
                else if (!w_hold_max) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_last  <= ID_W'(NUM_REQ - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
            r_id    <= w_id_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_preempt <= 1'b0;
        else     r_preempt <= w_preempt_nxt;
    end
    assign preempt = r_preempt;
`else
    assign preempt = 1'b0;
`endif

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_id    = r_id;
    assign hold_cnt    = r_hold;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: a cycle model pushes expected outputs as
// stimulus is driven; they are popped and compared on the following falling edge.
module tb_rr_grant_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [4:0] hold_cnt;
    logic       preempt;

    always #5 clk = ~clk;

    rr_grant_scheduler #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
        .hold_cnt(hold_cnt), .preempt(preempt)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic       gv;
        logic [1:0] id;
        logic [4:0] hold;
        logic       pre;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_miscmp = 0;

    bit         m_own;
    int         m_last, m_id, m_hold;
    logic [3:0] m_grant;
    logic       m_pre;

    bit   rec_order = 1'b0;
    int   order_q[$];
    logic prev_gv = 1'b0;
    bit   saw_pre = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 1'b0; m_last = NUM_REQ - 1; m_id = 0; m_hold = 0;
        m_grant = '0; m_pre = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] d);
        m_pre = 1'b0;
        if (!m_own) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_last + 1 + k) % NUM_REQ;
                if (!m_own && r[c]) begin
                    m_own = 1'b1; m_id = c; m_last = c; m_grant = 4'(1 << c); m_hold = 1;
                end
            end
        end else if (d[m_id] || !r[m_id]) begin
            m_own = 1'b0; m_id = 0; m_grant = '0; m_hold = 0;
`ifdef ARB_TIMEOUT_EN
        end else if (m_hold == MAX_HOLD && (r & ~m_grant) != 0) begin
            m_own = 1'b0; m_id = 0; m_grant = '0; m_hold = 0; m_pre = 1'b1;
`endif
        end else if (m_hold < MAX_HOLD) begin
            m_hold++;
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("grant",       32'(grant),       32'(e.grant));
            check("grant_valid", 32'(grant_valid), 32'(e.gv));
            check("grant_id",    32'(grant_id),    32'(e.id));
            check("hold_cnt",    32'(hold_cnt),    32'(e.hold));
            check("preempt",     32'(preempt),     32'(e.pre));
        end
        if (rec_order && grant_valid && !prev_gv) order_q.push_back(int'(grant_id));
        prev_gv = grant_valid;
        if (preempt) saw_pre = 1'b1;
        req = r;
        done = d;
        model_step(r, d);
        sb_q.push_back('{grant: m_grant, gv: (m_grant != 0), id: 2'(m_id),
                         hold: 5'(m_hold), pre: m_pre});
    endtask

    task automatic reset_dut();
        @(negedge clk);
        req = '0;
        done = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_grant",       32'(grant),       32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id",    32'(grant_id),    32'd0);
        check("rst_hold_cnt",    32'(hold_cnt),    32'd0);
        check("rst_preempt",     32'(preempt),     32'd0);
        sb_q.delete();
        model_reset();
        prev_gv = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] exp);
        check(tag, 32'(grant), 32'(exp));
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        model_reset();

        // 1: all requesting, each owner releases after 3 cycles
        reset_dut();
        rec_order = 1'b1;
        for (int i = 0; i < 20; i++)
            cycle(4'b1111, (m_own && m_hold == 3) ? 4'(1 << m_id) : 4'b0000);
        rec_order = 1'b0;
        for (int k = 0; k < 5; k++)
            check($sformatf("t1_order%0d", k),
                  (k < order_q.size()) ? 32'(order_q[k]) : 32'hffff_ffff, 32'(exp_order[k]));

        // 2: non-owner req and done ignored while 1 holds
        reset_dut();
        cycle(4'b0010, 4'b0000);
        cycle(4'b1010, 4'b0000);
        cycle(4'b1010, 4'b0100);
        cycle(4'b1010, 4'b0000);
        expect_grant("t2_hold_after_done2", 4'b0010);
        cycle(4'b1010, 4'b0010);
        cycle(4'b1000, 4'b0000);
        cycle(4'b1000, 4'b0000);
        expect_grant("t2_next_owner3", 4'b1000);

        // 3: lone requester drops req after 5 cycles then returns
        reset_dut();
        for (int i = 0; i < 5; i++) cycle(4'b0100, 4'b0000);
        cycle(4'b0000, 4'b0000);
        check("t3_hold5", 32'(hold_cnt), 32'd5);
        cycle(4'b0000, 4'b0000);
        check("t3_hold0", 32'(hold_cnt), 32'd0);
        cycle(4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0000);
        expect_grant("t3_regrant", 4'b0100);

        // 4: req0 held forever, req2 joins at cycle 3
        reset_dut();
        saw_pre = 1'b0;
        for (int i = 0; i < 30; i++) cycle((i >= 3) ? 4'b0101 : 4'b0001, 4'b0000);
`ifdef ARB_TIMEOUT_EN
        check("t4_preempt_seen", 32'(saw_pre), 32'd1);
        expect_grant("t4_grant_moved", 4'b0100);
`else
        check("t4_no_preempt", 32'(saw_pre), 32'd0);
        expect_grant("t4_grant_kept", 4'b0001);
        check("t4_hold_sat", 32'(hold_cnt), 32'(MAX_HOLD));
`endif

        // 5: async reset while requester 2 owns
        reset_dut();
        for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0000);
        expect_grant("t5_pre_rst", 4'b0100);
        reset_dut();
        cycle(4'b1111, 4'b0000);
        cycle(4'b1111, 4'b0000);
        expect_grant("t5_first_after_rst", 4'b0001);

        // 6: owner 3 releases with req=1001, pointer wraps to 0
        reset_dut();
        cycle(4'b1000, 4'b0000);
        cycle(4'b1001, 4'b0000);
        expect_grant("t6_owner3", 4'b1000);
        cycle(4'b1001, 4'b1000);
        cycle(4'b1001, 4'b0000);
        cycle(4'b1001, 4'b0000);
        expect_grant("t6_wrap_to0", 4'b0001);
        cycle(4'b1001, 4'b0001);
        cycle(4'b1001, 4'b0000);
        cycle(4'b1001, 4'b0000);
        expect_grant("t6_then3", 4'b1000);

        cycle(4'b0000, 4'b0000);
        cycle(4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
